writeback_arbiter: RTL and testbench

- Sits directly downstream of the execute stage.
- Collects the register-writing commit streams (ALU, LD, CSR, FPU, GPU) and merges them into the single register-file writeback port, granting one write per cycle round-robin.
- Commits that carry no writeback are consumed without using the port.
- Keeps a commit-retirement counter for the CSR performance block.

---
 rtl/writeback_arbiter_pkg.sv | 29 ++
 rtl/wb_rr_arbiter.sv | 38 +++
 rtl/writeback_arbiter.sv | 83 ++++++++
 tb/tb_writeback_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// writeback_arbiter_pkg: shared commit payload type, source indices and helpers
package writeback_arbiter_pkg;
    localparam int WB_NUM_SRCS    = 5;
    localparam int WB_NUM_THREADS = 4;
    localparam int WB_NUM_WARPS   = 4;
    localparam int NW_BITS        = (WB_NUM_WARPS > 1) ? $clog2(WB_NUM_WARPS) : 1;
    localparam int WB_NR_BITS     = 6;
    localparam int WB_XLEN        = 32;

    localparam int SRC_ALU = 0;
    localparam int SRC_LD  = 1;
    localparam int SRC_CSR = 2;
    localparam int SRC_FPU = 3;
    localparam int SRC_GPU = 4;

    typedef struct packed {
        logic [NW_BITS-1:0]                wid;
        logic [WB_NUM_THREADS-1:0]         tmask;
        logic [WB_NR_BITS-1:0]             rd;
        logic                              wb;
        logic [WB_NUM_THREADS*WB_XLEN-1:0] data;
        logic                              eop;
    } commit_t;

    function automatic logic [63:0] popcount(input logic [WB_NUM_SRCS-1:0] v);
        popcount = '0;
        for (int i = 0; i < WB_NUM_SRCS; i++) popcount += 64'(v[i]);
    endfunction
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin single grant starting the search at rr_ptr
module wb_rr_arbiter #(
    parameter int NUM_SRCS = 5,
    localparam int IDX_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_SRCS-1:0] req,
    input  logic                enable,
    output logic [NUM_SRCS-1:0] grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);
    logic [IDX_W-1:0] rr_ptr;
    int j;

    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        j           = 0;
        for (int k = 0; k < NUM_SRCS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_SRCS) j -= NUM_SRCS;
            if (enable && !grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(j);
            end
        end
        grant = grant_valid ? (NUM_SRCS'(1) << grant_idx) : '0;
    end

    // pointer moves just past the winner so it becomes lowest priority next time
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            rr_ptr <= '0;
        else if (grant_valid)
            rr_ptr <= (int'(grant_idx) == NUM_SRCS - 1) ? '0 : grant_idx + IDX_W'(1);
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges commit streams into one registered register-file write port
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int NUM_SRCS    = WB_NUM_SRCS,
    parameter int NUM_THREADS = WB_NUM_THREADS,
    parameter int NUM_WARPS   = WB_NUM_WARPS,
    parameter int NR_BITS     = WB_NR_BITS,
    parameter int XLEN        = WB_XLEN,
    localparam int WID_W = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int IDX_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [NUM_SRCS-1:0]                   cmt_valid_i,
    output logic [NUM_SRCS-1:0]                   cmt_ready_o,
    input  logic [NUM_SRCS*WID_W-1:0]             cmt_wid_i,
    input  logic [NUM_SRCS*NUM_THREADS-1:0]       cmt_tmask_i,
    input  logic [NUM_SRCS*NR_BITS-1:0]           cmt_rd_i,
    input  logic [NUM_SRCS-1:0]                   cmt_wb_i,
    input  logic [NUM_SRCS*NUM_THREADS*XLEN-1:0]  cmt_data_i,
    input  logic [NUM_SRCS-1:0]                   cmt_eop_i,
    output logic                                  wb_valid_o,
    output logic [WID_W-1:0]                      wb_wid_o,
    output logic [NUM_THREADS-1:0]                wb_tmask_o,
    output logic [NR_BITS-1:0]                    wb_rd_o,
    output logic [NUM_THREADS*XLEN-1:0]           wb_data_o,
    output logic                                  wb_eop_o,
    output logic [63:0]                           perf_commits_o
);
    localparam int DW = NUM_THREADS * XLEN;

    commit_t             cmt [NUM_SRCS];
    logic [NUM_SRCS-1:0] req, drop, grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;

    for (genvar g = 0; g < NUM_SRCS; g++) begin : g_src
        assign cmt[g] = '{wid:   cmt_wid_i[g*WID_W +: WID_W],
                          tmask: cmt_tmask_i[g*NUM_THREADS +: NUM_THREADS],
                          rd:    cmt_rd_i[g*NR_BITS +: NR_BITS],
                          wb:    cmt_wb_i[g],
                          data:  cmt_data_i[g*DW +: DW],
                          eop:   cmt_eop_i[g]};
        assign req[g] = cmt_valid_i[g] & cmt[g].wb & (cmt[g].rd != '0);
    end

    // commits without a real destination retire immediately alongside the winner
    assign drop        = cmt_valid_i & ~req;
    assign cmt_ready_o = grant | drop;

    wb_rr_arbiter #(.NUM_SRCS(NUM_SRCS)) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .enable      (1'b1),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid_o     <= 1'b0;
            wb_wid_o       <= '0;
            wb_tmask_o     <= '0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
            wb_eop_o       <= 1'b0;
            perf_commits_o <= '0;
        end else begin
            wb_valid_o <= grant_valid;
            if (grant_valid) begin
                wb_wid_o   <= cmt[grant_idx].wid;
                wb_tmask_o <= cmt[grant_idx].tmask;
                wb_rd_o    <= cmt[grant_idx].rd;
                wb_data_o  <= cmt[grant_idx].data;
                wb_eop_o   <= cmt[grant_idx].eop;
            end
            perf_commits_o <= perf_commits_o + popcount(cmt_valid_i & cmt_ready_o);
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed and randomized checks against a scan-order reference model
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;
    localparam int NS = WB_NUM_SRCS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NS-1:0] cmt_valid_i, cmt_ready_o, cmt_wb_i, cmt_eop_i;
    logic [NS*2-1:0]   cmt_wid_i;
    logic [NS*4-1:0]   cmt_tmask_i;
    logic [NS*6-1:0]   cmt_rd_i;
    logic [NS*128-1:0] cmt_data_i;
    logic          wb_valid_o, wb_eop_o;
    logic [1:0]    wb_wid_o;
    logic [3:0]    wb_tmask_o;
    logic [5:0]    wb_rd_o;
    logic [127:0]  wb_data_o;
    logic [63:0]   perf_commits_o;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cmt_valid_i(cmt_valid_i), .cmt_ready_o(cmt_ready_o), .cmt_wid_i(cmt_wid_i),
        .cmt_tmask_i(cmt_tmask_i), .cmt_rd_i(cmt_rd_i), .cmt_wb_i(cmt_wb_i),
        .cmt_data_i(cmt_data_i), .cmt_eop_i(cmt_eop_i),
        .wb_valid_o(wb_valid_o), .wb_wid_o(wb_wid_o), .wb_tmask_o(wb_tmask_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_eop_o(wb_eop_o),
        .perf_commits_o(perf_commits_o)
    );

    bit           t_v [NS];
    bit           t_wb [NS];
    bit           t_eop [NS];
    logic [1:0]   t_wid [NS];
    logic [3:0]   t_tm [NS];
    logic [5:0]   t_rd [NS];
    logic [127:0] t_d [NS];

    int              m_ptr, m_g;
    longint unsigned m_perf;
    logic [NS-1:0]   m_ready;
    logic            e_valid, e_eop;
    logic [1:0]      e_wid;
    logic [3:0]      e_tm;
    logic [5:0]      e_rd;
    logic [127:0]    e_data;
    int              checks = 0, errors = 0;

    task automatic drive();
        for (int i = 0; i < NS; i++) begin
            cmt_valid_i[i]          = t_v[i];
            cmt_wb_i[i]             = t_wb[i];
            cmt_eop_i[i]            = t_eop[i];
            cmt_wid_i[i*2 +: 2]     = t_wid[i];
            cmt_tmask_i[i*4 +: 4]   = t_tm[i];
            cmt_rd_i[i*6 +: 6]      = t_rd[i];
            cmt_data_i[i*128 +: 128] = t_d[i];
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NS; i++) begin
            t_v[i] = 0; t_wb[i] = 0; t_eop[i] = 0;
            t_wid[i] = '0; t_tm[i] = '0; t_rd[i] = '0; t_d[i] = '0;
        end
        drive();
    endtask

    task automatic model_reset();
        m_ptr = 0; m_perf = 0;
        e_valid = 0; e_eop = 0; e_wid = '0; e_tm = '0; e_rd = '0; e_data = '0;
    endtask

    // winner is the first writing source met walking round from the pointer
    task automatic model_eval();
        m_ready = '0;
        m_g = -1;
        for (int k = 0; k < NS; k++) begin
            int i = (m_ptr + k) % NS;
            if (m_g < 0 && t_v[i] && t_wb[i] && t_rd[i] != 0) m_g = i;
        end
        for (int i = 0; i < NS; i++)
            if (t_v[i] && (i == m_g || !t_wb[i] || t_rd[i] == 0)) m_ready[i] = 1'b1;
    endtask

    task automatic model_commit();
        m_perf += longint'($countones(m_ready));
        e_valid = (m_g >= 0);
        if (m_g >= 0) begin
            e_wid = t_wid[m_g]; e_tm = t_tm[m_g]; e_rd = t_rd[m_g];
            e_data = t_d[m_g]; e_eop = t_eop[m_g];
            m_ptr = (m_g + 1) % NS;
        end
        for (int i = 0; i < NS; i++) if (m_ready[i]) t_v[i] = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_srcs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            checks++;
            if (wb_valid_o !== 1'b0 || cmt_ready_o !== '0 || perf_commits_o !== 64'd0) begin
                errors++;
                $display("FAIL reset_idle c=%0d: valid=%b ready=%b perf=%0d, want 0/0/0",
                         c, wb_valid_o, cmt_ready_o, perf_commits_o);
            end
        end
        checks++;
        if (wb_rd_o !== 6'd0 || wb_data_o !== 128'd0) begin
            errors++;
            $display("FAIL reset_payload: rd=%0d data=%h, want 0", wb_rd_o, wb_data_o);
        end
    endtask

    task automatic test_alu_single();
        do_reset();
        t_v[SRC_ALU] = 1; t_wb[SRC_ALU] = 1; t_rd[SRC_ALU] = 6'd5; t_wid[SRC_ALU] = 2'd2;
        t_tm[SRC_ALU] = 4'b1011; t_eop[SRC_ALU] = 1;
        t_d[SRC_ALU] = {32'h44, 32'h33, 32'h22, 32'h11};
        drive(); #1; model_eval();
        checks++;
        if (cmt_ready_o !== 5'b00001) begin
            errors++; $display("FAIL alu_ready: got %b want 00001", cmt_ready_o);
        end
        @(posedge clk); model_commit(); #1; drive();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 6'd5 || wb_wid_o !== 2'd2 || wb_tmask_o !== 4'b1011 ||
            wb_eop_o !== 1'b1 || wb_data_o !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
            errors++;
            $display("FAIL alu_wb: v=%b rd=%0d wid=%0d tm=%b eop=%b data=%h want 1/5/2/1011/1/00000044000000330000002200000011",
                     wb_valid_o, wb_rd_o, wb_wid_o, wb_tmask_o, wb_eop_o, wb_data_o);
        end
        checks++;
        if (perf_commits_o !== 64'd1) begin
            errors++; $display("FAIL alu_perf: got %0d want 1", perf_commits_o);
        end
        @(posedge clk); #1;
        checks++;
        if (wb_valid_o !== 1'b0 || wb_rd_o !== 6'd5) begin
            errors++; $display("FAIL alu_pulse: valid=%b rd=%0d want 0 with rd held at 5", wb_valid_o, wb_rd_o);
        end
    endtask

    task automatic test_all_request();
        do_reset();
        for (int i = 0; i < NS; i++) begin
            t_wb[i] = 1; t_rd[i] = 6'(i + 1); t_wid[i] = 2'($urandom); t_tm[i] = 4'($urandom);
            t_d[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < NS; i++) t_v[i] = 1;
            drive(); #1; model_eval();
            checks++;
            if (cmt_ready_o !== NS'(1 << (k % NS))) begin
                errors++; $display("FAIL all_ready k=%0d: got %b want %b", k, cmt_ready_o, NS'(1 << (k % NS)));
            end
            @(posedge clk); model_commit(); #1;
            checks++;
            if (wb_valid_o !== 1'b1 || wb_rd_o !== 6'(k % NS + 1)) begin
                errors++; $display("FAIL all_order k=%0d: valid=%b rd=%0d want 1/%0d", k, wb_valid_o, wb_rd_o, k % NS + 1);
            end
        end
        checks++;
        if (perf_commits_o !== 64'd10) begin
            errors++; $display("FAIL all_perf: got %0d want 10", perf_commits_o);
        end
    endtask

    task automatic test_drops();
        do_reset();
        t_v[SRC_LD]  = 1; t_wb[SRC_LD]  = 0; t_rd[SRC_LD]  = 6'd7;
        t_v[SRC_CSR] = 1; t_wb[SRC_CSR] = 1; t_rd[SRC_CSR] = 6'd0;
        t_v[SRC_FPU] = 1; t_wb[SRC_FPU] = 1; t_rd[SRC_FPU] = 6'd33; t_tm[SRC_FPU] = 4'b0000;
        drive(); #1; model_eval();
        checks++;
        if (cmt_ready_o !== 5'b01110) begin
            errors++; $display("FAIL drop_ready: got %b want 01110", cmt_ready_o);
        end
        @(posedge clk); model_commit(); #1; drive();
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 6'd33 || wb_tmask_o !== 4'b0000 || perf_commits_o !== 64'd3) begin
            errors++;
            $display("FAIL drop_wb: valid=%b rd=%0d tm=%b perf=%0d want 1/33/0000/3",
                     wb_valid_o, wb_rd_o, wb_tmask_o, perf_commits_o);
        end
        @(posedge clk); #1;
        checks++;
        if (wb_valid_o !== 1'b0) begin
            errors++; $display("FAIL drop_single: valid=%b want 0", wb_valid_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        t_v[SRC_FPU] = 1; t_wb[SRC_FPU] = 1; t_rd[SRC_FPU] = 6'd9;
        drive(); #1; model_eval(); @(posedge clk); model_commit(); #1;
        t_v[SRC_GPU] = 1; t_wb[SRC_GPU] = 1; t_rd[SRC_GPU] = 6'd10;
        drive(); #1; model_eval(); @(posedge clk); model_commit(); #1;
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 6'd10) begin
            errors++; $display("FAIL wrap_gpu: valid=%b rd=%0d want 1/10", wb_valid_o, wb_rd_o);
        end
        t_v[SRC_ALU] = 1; t_wb[SRC_ALU] = 1; t_rd[SRC_ALU] = 6'd1;
        t_v[SRC_FPU] = 1;
        drive(); #1; model_eval();
        checks++;
        if (cmt_ready_o !== 5'b00001) begin
            errors++; $display("FAIL wrap_alu_first: got %b want 00001", cmt_ready_o);
        end
        @(posedge clk); model_commit(); #1; drive(); #1;
        checks++;
        if (wb_rd_o !== 6'd1 || cmt_ready_o !== 5'b01000) begin
            errors++; $display("FAIL wrap_fpu_next: rd=%0d ready=%b want 1/01000", wb_rd_o, cmt_ready_o);
        end
        model_eval(); @(posedge clk); model_commit(); #1;
        checks++;
        if (wb_valid_o !== 1'b1 || wb_rd_o !== 6'd9) begin
            errors++; $display("FAIL wrap_fpu_wb: valid=%b rd=%0d want 1/9", wb_valid_o, wb_rd_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++)
                if (!t_v[i] && $urandom_range(2) == 0) begin
                    t_v[i] = 1; t_wb[i] = ($urandom_range(3) != 0); t_eop[i] = 1'($urandom);
                    t_rd[i] = ($urandom_range(3) == 0) ? 6'd0 : 6'($urandom_range(63, 1));
                    t_wid[i] = 2'($urandom); t_tm[i] = 4'($urandom);
                    t_d[i] = {$urandom, $urandom, $urandom, $urandom};
                end
            drive(); #1; model_eval();
            checks++;
            if (cmt_ready_o !== m_ready) begin
                errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, cmt_ready_o, m_ready);
            end
            @(posedge clk); model_commit(); #1;
            checks++;
            if (wb_valid_o !== e_valid || wb_rd_o !== e_rd || wb_wid_o !== e_wid || wb_tmask_o !== e_tm ||
                wb_data_o !== e_data || wb_eop_o !== e_eop) begin
                errors++;
                $display("FAIL rnd_wb c=%0d: v=%b rd=%0d wid=%0d tm=%b eop=%b data=%h want v=%b rd=%0d wid=%0d tm=%b eop=%b data=%h",
                         c, wb_valid_o, wb_rd_o, wb_wid_o, wb_tmask_o, wb_eop_o, wb_data_o,
                         e_valid, e_rd, e_wid, e_tm, e_eop, e_data);
            end
            checks++;
            if (perf_commits_o !== m_perf) begin
                errors++; $display("FAIL rnd_perf c=%0d: got %0d want %0d", c, perf_commits_o, m_perf);
            end
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < NS; i++) begin
            t_v[i] = 1; t_wb[i] = 1; t_rd[i] = 6'(i + 1);
        end
        drive(); #1; model_eval(); @(posedge clk); model_commit(); #1;
        checks++;
        if (wb_valid_o !== 1'b1) begin
            errors++; $display("FAIL async_setup: valid=%b want 1", wb_valid_o);
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (wb_valid_o !== 1'b0 || perf_commits_o !== 64'd0 || wb_rd_o !== 6'd0) begin
            errors++;
            $display("FAIL async_clear: valid=%b perf=%0d rd=%0d want 0/0/0", wb_valid_o, perf_commits_o, wb_rd_o);
        end
        clear_srcs();
        model_reset();
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) begin
            t_v[i] = 1; t_wb[i] = 1; t_rd[i] = 6'(i + 1);
        end
        drive(); #1; model_eval();
        checks++;
        if (cmt_ready_o !== 5'b00001) begin
            errors++; $display("FAIL async_ptr: ready=%b want 00001", cmt_ready_o);
        end
        @(posedge clk); model_commit(); #1;
        checks++;
        if (wb_rd_o !== 6'd1 || perf_commits_o !== 64'd1) begin
            errors++; $display("FAIL async_after: rd=%0d perf=%0d want 1/1", wb_rd_o, perf_commits_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_all_request();
        test_drops();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
